canvas_ctrl: RTL
================

# canvas_ctrl

Owner and arbiter of the 32×32 one-bit drawing canvas that sits between the mouse/VGA front end and the DNN classifier. It serialises three requesters onto one canvas store: pixel writes from the mouse path, a full-canvas clear, and a column-by-column scan stream to the inference engine. It also provides a combinational column read port for the VGA renderer and a flat 1024-bit view for the classifier input.

## Interface
Parameters:
- DIM, 32, canvas edge length in pixels; fixed, listed for readability only.
- AW, 5, index width; equals log2(DIM).

Ports:
- iClk  in  1  single clock; all state changes on its rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iDrawReq  in  1  request a pixel write; held by the requester until acked.
- iDrawX  in  AW  pixel column x.
- iDrawY  in  AW  pixel row y.
- iDrawVal  in  1  value to write: 1 sets the pixel, 0 erases it.
- oDrawAck  out  1  one-cycle pulse; the write has been performed.
- iClearReq  in  1  pulse requesting a full-canvas clear.
- oClearBusy  out  1  high while clearing.
- iScanStart  in  1  pulse requesting a scan to the classifier.
- oScanValid  out  1  oScanCol/oScanData are valid.
- iScanReady  in  1  classifier accepts the current column.
- oScanCol  out  AW  index of the column being presented.
- oScanData  out  DIM  column contents; bit y is pixel (x, y).
- oScanDone  out  1  one-cycle pulse after the last column handshake.
- iVidCol  in  AW  VGA read column.
- oVidData  out  DIM  combinational contents of column iVidCol.
- oImage  out  DIM*DIM  flat canvas; bit x*32+y is pixel (x, y).

## Operation
- Storage: 32 column words. Word x holds pixels (x, 0..31).
- FSM states: IDLE, CLEAR, SCAN.
- Pending flags clrPend and scanPend.
  - iClearReq or iScanStart high in any state sets the corresponding flag.
  - A flag clears when its operation starts.
- IDLE priority, evaluated each edge: clrPend or iClearReq → CLEAR; else scanPend or iScanStart → SCAN; else iDrawReq → write pixel.
- IDLE draw:
  - The write happens on the accepting edge. oDrawAck is high for the next cycle.
  - A request still held while ack is high is accepted again. This is idempotent.
- Draw requests are never acked in CLEAR or SCAN. The requester keeps iDrawReq asserted.
- CLEAR:
  - Column pointer starts at 0 and one column is zeroed per cycle.
  - After column 31 is zeroed, the FSM returns to IDLE.
- SCAN:
  - Column pointer starts at 0 and oScanValid is high.
  - The pointer advances on oScanValid && iScanReady.
  - Handshake on column 31 → oScanDone pulses and the FSM returns to IDLE.
- A clear requested during SCAN is deferred until the scan ends. Scan data is never corrupted mid-stream.
- A scan requested during CLEAR runs after the clear completes and sees an all-zero canvas.
- A scan requested during SCAN sets scanPend, so a second scan follows.
- oVidData and oImage always reflect the store contents, including partially cleared states.

## Timing
- Reset (async, iRst=1) sets the canvas to all zeros and the FSM to IDLE, and clears both pending flags and the pointer. All outputs are then 0: oDrawAck, oClearBusy, oScanValid, oScanCol, oScanData, oScanDone. oVidData and oImage are also 0.
- Reset mid-CLEAR or mid-SCAN aborts the operation. No oScanDone is issued.
- Draw:
  - Pixel visible on oImage/oVidData the cycle after the accepting edge, the same cycle as oDrawAck.
  - Latency from iDrawReq to ack is 1 cycle when IDLE with no pending work.
- Clear:
  - oClearBusy rises the cycle after acceptance and stays high for exactly 32 cycles.
  - It falls in the same cycle the FSM is back in IDLE.
- Scan:
  - oScanValid rises the cycle after acceptance, presenting column 0.
  - oScanCol and oScanData stay stable while oScanValid && !iScanReady.
  - With iScanReady tied high: 32 valid cycles, then oScanDone high for 1 cycle while oScanValid is 0.
- Simultaneous iClearReq and iScanStart in IDLE: CLEAR runs first, then SCAN.
- Simultaneous iClearReq and iDrawReq in IDLE: the clear wins and the draw waits.

## Structure
- Package canvas_pkg holds:
  - CANVAS_DIM=32 and CANVAS_AW=5.
  - State enum {ST_IDLE, ST_CLEAR, ST_SCAN}.
  - Helper constant for the flat index width (10).
- Sub-module canvas_store:
  - 32×32 register array.
  - One write port: column index, bit index, value, and a whole-column-clear enable.
  - Two combinational column read ports, for scan and video.
  - Flat oImage output.
  - Async reset to zero.
- canvas_ctrl holds only the FSM, the pending flags, the pointer and the handshake outputs.

## Test plan
- Reset, then draw (x=3, y=7, val=1) → oDrawAck one cycle later; oImage[103]=1 and oVidData[7]=1 with iVidCol=3; all other bits 0.
- Set 5 pixels, then pulse iClearReq → oClearBusy high exactly 32 cycles; oImage==0 after; a draw held during the clear is acked on the first IDLE cycle.
- Canvas with column 0 = 32'h0000_0001 and column 31 = 32'h8000_0000, iScanReady=1 → 32 valid beats with oScanCol 0..31 and matching data; oScanDone pulses the cycle after beat 31.
- Scan with iScanReady toggling 1,0,0,1… → each column is accepted exactly once, data is stable while stalled, and the beat count is 32.
- iClearReq during scan beat 10 → scan completes with the original data, then the 32-cycle clear runs, and the final oImage==0.
- Assert iRst at scan beat 15 → oScanValid=0 immediately; no oScanDone; canvas zero; FSM IDLE.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared constants, FSM state encoding and pixel-index helper for the
// 32x32 one-bit drawing canvas.
package canvas_pkg;

    localparam int CANVAS_DIM     = 32;
    localparam int CANVAS_AW      = 5;
    localparam int CANVAS_FLAT_AW = 2 * CANVAS_AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN
    } state_t;

    // Flat pixel index as used on oImage: bit x*32+y is pixel (x, y).
    function automatic logic [CANVAS_FLAT_AW-1:0] flatIndex(
        input logic [CANVAS_AW-1:0] x,
        input logic [CANVAS_AW-1:0] y
    );
        return {x, y};
    endfunction

endpackage

// File: rtl/canvas_store.sv
// Canvas storage: 32 column words with one write/column-clear port,
// two combinational column read ports and a flat view of the whole canvas.
module canvas_store
    import canvas_pkg::*;
#(
    parameter int DIM = CANVAS_DIM,
    parameter int AW  = CANVAS_AW
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iWrEn,
    input  logic                 iClrEn,
    input  logic [AW-1:0]        iWrCol,
    input  logic [AW-1:0]        iWrRow,
    input  logic                 iWrVal,
    input  logic [AW-1:0]        iScanCol,
    output logic [DIM-1:0]       oScanData,
    input  logic [AW-1:0]        iVidCol,
    output logic [DIM-1:0]       oVidData,
    output logic [DIM*DIM-1:0]   oImage
);

    logic [DIM-1:0] mem [DIM];

    // A column clear takes precedence over a pixel write to the same port.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < DIM; i++) begin
                mem[i] <= '0;
            end
        end else if (iClrEn) begin
            mem[iWrCol] <= '0;
        end else if (iWrEn) begin
            mem[iWrCol][iWrRow] <= iWrVal;
        end
    end

    assign oScanData = mem[iScanCol];
    assign oVidData  = mem[iVidCol];

    for (genvar g = 0; g < DIM; g++) begin : gFlat
        assign oImage[g*DIM +: DIM] = mem[g];
    end

endmodule

// File: rtl/canvas_ctrl.sv
// Canvas arbiter: serialises pixel draws, full clears and the column scan
// stream to the classifier onto a single canvas store.
module canvas_ctrl
    import canvas_pkg::*;
#(
    parameter int DIM = CANVAS_DIM,
    parameter int AW  = CANVAS_AW
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iDrawReq,
    input  logic [AW-1:0]        iDrawX,
    input  logic [AW-1:0]        iDrawY,
    input  logic                 iDrawVal,
    output logic                 oDrawAck,
    input  logic                 iClearReq,
    output logic                 oClearBusy,
    input  logic                 iScanStart,
    output logic                 oScanValid,
    input  logic                 iScanReady,
    output logic [AW-1:0]        oScanCol,
    output logic [DIM-1:0]       oScanData,
    output logic                 oScanDone,
    input  logic [AW-1:0]        iVidCol,
    output logic [DIM-1:0]       oVidData,
    output logic [DIM*DIM-1:0]   oImage
);

    localparam logic [AW-1:0] LAST_COL = AW'(DIM - 1);

    state_t        state, stateNext;
    logic [AW-1:0] ptr, ptrNext;
    logic          clrPend, clrPendNext;
    logic          scanPend, scanPendNext;
    logic          drawAck, drawAckNext;
    logic          scanDone, scanDoneNext;
    logic          wrEn, clrEn;
    logic [AW-1:0] storeCol;
    logic [DIM-1:0] scanColData;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            clrPend  <= 1'b0;
            scanPend <= 1'b0;
            drawAck  <= 1'b0;
            scanDone <= 1'b0;
        end else begin
            state    <= stateNext;
            ptr      <= ptrNext;
            clrPend  <= clrPendNext;
            scanPend <= scanPendNext;
            drawAck  <= drawAckNext;
            scanDone <= scanDoneNext;
        end
    end

    // Requests arriving in any state are latched; a flag drops only when its
    // operation is launched from IDLE, so a clear never interrupts a scan.
    always_comb begin
        stateNext    = state;
        ptrNext      = ptr;
        clrPendNext  = clrPend | iClearReq;
        scanPendNext = scanPend | iScanStart;
        drawAckNext  = 1'b0;
        scanDoneNext = 1'b0;
        wrEn         = 1'b0;
        clrEn        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clrPend || iClearReq) begin
                    stateNext   = ST_CLEAR;
                    ptrNext     = '0;
                    clrPendNext = 1'b0;
                end else if (scanPend || iScanStart) begin
                    stateNext    = ST_SCAN;
                    ptrNext      = '0;
                    scanPendNext = 1'b0;
                end else if (iDrawReq) begin
                    wrEn        = 1'b1;
                    drawAckNext = 1'b1;
                end
            end
            ST_CLEAR: begin
                clrEn = 1'b1;
                if (ptr == LAST_COL) begin
                    stateNext = ST_IDLE;
                    ptrNext   = '0;
                end else begin
                    ptrNext = ptr + AW'(1);
                end
            end
            ST_SCAN: begin
                if (iScanReady) begin
                    if (ptr == LAST_COL) begin
                        stateNext    = ST_IDLE;
                        ptrNext      = '0;
                        scanDoneNext = 1'b1;
                    end else begin
                        ptrNext = ptr + AW'(1);
                    end
                end
            end
            default: begin
                stateNext = ST_IDLE;
                ptrNext   = '0;
            end
        endcase
    end

    // Draws address the store from the mouse path; clears walk the pointer.
    assign storeCol = (state == ST_IDLE) ? iDrawX : ptr;

    canvas_store #(
        .DIM (DIM),
        .AW  (AW)
    ) uStore (
        .iClk      (iClk),
        .iRst      (iRst),
        .iWrEn     (wrEn),
        .iClrEn    (clrEn),
        .iWrCol    (storeCol),
        .iWrRow    (iDrawY),
        .iWrVal    (iDrawVal),
        .iScanCol  (ptr),
        .oScanData (scanColData),
        .iVidCol   (iVidCol),
        .oVidData  (oVidData),
        .oImage    (oImage)
    );

    assign oDrawAck   = drawAck;
    assign oClearBusy = (state == ST_CLEAR);
    assign oScanValid = (state == ST_SCAN);
    assign oScanCol   = oScanValid ? ptr : '0;
    assign oScanData  = oScanValid ? scanColData : '0;
    assign oScanDone  = scanDone;

endmodule
